// File: rtl/ov7670_stream_gen_if.sv
// ov7670_stream_gen_if: groups the frame-buffer read port and the OV7670
// pin-side stream of ov7670_stream_gen.
//   master : the generator. It drives the read strobe/address and the
//            pclk/vs/hs/data stream. It samples i_rd_data.
//   slave  : frame buffer / stream consumer side.
interface ov7670_stream_gen_if #(
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10
);
  logic                      o_rd_en;
  logic [CAM_LINE-1:0]       o_rd_line;
  logic [CAM_PIXEL-1:0]      o_rd_pixel;
  logic [CAM_DATA_WIDTH-1:0] i_rd_data;
  logic                      o_pclk;
  logic                      o_vs;
  logic                      o_hs;
  logic [7:0]                o_data;
  logic                      o_busy;
  logic                      o_frame_done;

  modport master (
    output o_rd_en, o_rd_line, o_rd_pixel, o_pclk, o_vs, o_hs, o_data,
           o_busy, o_frame_done,
    input  i_rd_data
  );

  modport slave (
    input  o_rd_en, o_rd_line, o_rd_pixel, o_pclk, o_vs, o_hs, o_data,
           o_busy, o_frame_done,
    output i_rd_data
  );
endinterface

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: replays frame-buffer contents as an OV7670-style
// parallel stream. The stream uses PCLK = clk/2, VSYNC, HREF and 8-bit data.
// Each RGB444 pixel is sent as {4'h0,R} followed by {G,B}.
// Ports:
//   clk      system clock. One stream byte lasts 2 clk.
//   reset_n  synchronous active-low reset.
//   en       level input. Frames run back to back while it is high.
//   bus      ov7670_stream_gen_if.master. Carries the read strobe and
//            address, the read data (1 clk latency), pclk/vs/hs/data,
//            busy and the frame-done pulse.
module ov7670_stream_gen #(
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10,
  parameter int H_ACTIVE       = 640,
  parameter int H_BLANK        = 288,
  parameter int V_ACTIVE       = 480,
  parameter int VSYNC_LEN      = 3,
  parameter int V_BACK         = 17,
  parameter int V_FRONT        = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  ov7670_stream_gen_if.master bus
);

  localparam int LB   = 2 * H_ACTIVE + H_BLANK;
  localparam int BW   = (LB > 1) ? $clog2(LB + 1) : 1;
  localparam int MAXA = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int MAXB = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAXL = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int LW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [BW-1:0] LB_LAST   = BW'(LB - 1);
  localparam logic [BW-1:0] ACT_BYTES = BW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } st_e;

  // The last byte of this state's final line carries the (0,0) prefetch.
  localparam st_e PRE_ACT = (V_BACK > 0) ? VBACK : VSYNC;

  function automatic logic has_lines(st_e s);
    case (s)
      VSYNC:   return VSYNC_LEN > 0;
      VBACK:   return V_BACK > 0;
      ACTIVE:  return V_ACTIVE > 0;
      VFRONT:  return V_FRONT > 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LW-1:0] last_line(st_e s);
    case (s)
      VSYNC:   return LW'(VSYNC_LEN - 1);
      VBACK:   return LW'(V_BACK - 1);
      ACTIVE:  return LW'(V_ACTIVE - 1);
      VFRONT:  return LW'(V_FRONT - 1);
      default: return '0;
    endcase
  endfunction

  function automatic st_e ring_next(st_e s);
    case (s)
      VSYNC:   return VBACK;
      VBACK:   return ACTIVE;
      ACTIVE:  return VFRONT;
      default: return VSYNC;
    endcase
  endfunction

  // Skip zero-length states.
  function automatic st_e first_nz(st_e s);
    st_e r;
    r = s;
    for (int i = 0; i < 4; i++)
      if (!has_lines(r)) r = ring_next(r);
    return r;
  endfunction

  // Leaving s wraps the ring back toward VSYNC, so s is the frame's last state.
  function automatic logic frame_end(st_e s);
    return first_nz(ring_next(s)) <= s;
  endfunction

  st_e                 state_q, state_d;
  logic                ph_q, ph_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [LW-1:0]       line_q, line_d;
  logic                rd_en_q, rd_en_d;
  logic [CAM_LINE-1:0] rd_line_q, rd_line_d;
  logic [CAM_PIXEL-1:0] rd_pix_q, rd_pix_d;
  logic                vs_q, hs_q, busy_q, done_q, done_d, act_d;
  logic [7:0]          data_q, lo_q;

  // Next position in the frame: phase, byte, line, state.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bcnt_d  = bcnt_q;
    line_d  = line_q;
    if (state_q == IDLE) begin
      ph_d   = 1'b0;
      bcnt_d = '0;
      line_d = '0;
      if (en) state_d = first_nz(VSYNC);
    end else begin
      ph_d = ~ph_q;
      if (ph_q) begin
        if (bcnt_q == LB_LAST) begin
          bcnt_d = '0;
          if (line_q == last_line(state_q)) begin
            line_d = '0;
            if (frame_end(state_q) && !en) state_d = IDLE;
            else                           state_d = first_nz(ring_next(state_q));
          end else begin
            line_d = line_q + LW'(1);
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
    end
  end

  // Outputs for the upcoming clk are decoded from the next position, so
  // every output below is a plain register.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_line_d = '0;
    rd_pix_d  = '0;
    act_d     = (state_d == ACTIVE) && (bcnt_d < ACT_BYTES);
    done_d    = (state_d != IDLE) && ph_d && (bcnt_d == LB_LAST) &&
                (line_d == last_line(state_d)) && frame_end(state_d);
    if (!ph_d && state_d != IDLE) begin
      if (state_d == ACTIVE && bcnt_d[0] && bcnt_d < ACT_BYTES - BW'(1)) begin
        // Byte 2k-1 fetches pixel k of the current line.
        rd_en_d   = 1'b1;
        rd_line_d = CAM_LINE'(line_d);
        rd_pix_d  = CAM_PIXEL'((bcnt_d + BW'(1)) >> 1);
      end else if (bcnt_d == LB_LAST && state_d == ACTIVE &&
                   line_d != last_line(ACTIVE)) begin
        // Last blank byte fetches pixel 0 of the next active line.
        rd_en_d   = 1'b1;
        rd_line_d = CAM_LINE'(line_d) + CAM_LINE'(1);
      end else if (bcnt_d == LB_LAST && state_d == PRE_ACT &&
                   line_d == last_line(PRE_ACT) && V_ACTIVE > 0) begin
        rd_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ph_q      <= 1'b0;
      bcnt_q    <= '0;
      line_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_line_q <= '0;
      rd_pix_q  <= '0;
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      data_q    <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bcnt_q    <= bcnt_d;
      line_q    <= line_d;
      rd_en_q   <= rd_en_d;
      rd_line_q <= rd_line_d;
      rd_pix_q  <= rd_pix_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      // Stream pins only move when pclk falls, so a new byte is starting.
      if (!ph_d) begin
        vs_q <= (state_d == VSYNC);
        hs_q <= act_d;
        if (act_d && !bcnt_d[0]) begin
          // Read data from the prefetch is valid on this edge.
          data_q <= {4'h0, bus.i_rd_data[CAM_DATA_WIDTH-1 -: 4]};
          lo_q   <= bus.i_rd_data[7:0];
        end else if (act_d) begin
          data_q <= lo_q;
        end else begin
          data_q <= '0;
        end
      end
    end
  end

  assign bus.o_rd_en      = rd_en_q;
  assign bus.o_rd_line    = rd_line_q;
  assign bus.o_rd_pixel   = rd_pix_q;
  assign bus.o_pclk       = ph_q;
  assign bus.o_vs         = vs_q;
  assign bus.o_hs         = hs_q;
  assign bus.o_data       = data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen with small frame parameters (LB=12, 24 clk/line,
// 144 clk/frame). Expected bytes and read addresses are queued when a frame
// is launched. A negedge monitor pops them as the stream produces them.
module tb_ov7670_stream_gen;
  localparam int DW = 12, LNW = 9, PXW = 10;

  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0;
  always #5 clk = ~clk;

  ov7670_stream_gen_if #(.CAM_DATA_WIDTH(DW), .CAM_LINE(LNW), .CAM_PIXEL(PXW)) bus ();

  ov7670_stream_gen #(
    .CAM_DATA_WIDTH(DW), .CAM_LINE(LNW), .CAM_PIXEL(PXW),
    .H_ACTIVE(4), .H_BLANK(4), .V_ACTIVE(3),
    .VSYNC_LEN(1), .V_BACK(1), .V_FRONT(1)
  ) dut (.clk(clk), .reset_n(reset_n), .en(en), .bus(bus));

  int checks = 0, failures = 0, cyc = 0, hb = 0;
  bit mon_on = 1'b0;
  logic [7:0]  exp_byte_q[$];
  logic [18:0] exp_addr_q[$];
  int          rd_stamp_q[$];
  logic [18:0] m_a;
  logic [7:0]  m_b;
  int          m_s;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer model: word at (L,k) = {L[3:0], k[3:0], 4'hA}, 1 clk latency.
  always @(posedge clk)
    if (bus.o_rd_en) bus.i_rd_data <= {bus.o_rd_line[3:0], bus.o_rd_pixel[3:0], 4'hA};

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.o_rd_en) begin
        rd_stamp_q.push_back(cyc);
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL rd_addr: extra strobe line=%0d pixel=%0d", bus.o_rd_line, bus.o_rd_pixel);
        end else begin
          m_a = exp_addr_q.pop_front();
          if ({bus.o_rd_line, bus.o_rd_pixel} !== m_a) begin
            failures++;
            $display("FAIL rd_addr: got line=%0d pixel=%0d want line=%0d pixel=%0d",
                     bus.o_rd_line, bus.o_rd_pixel, m_a[18:10], m_a[9:0]);
          end
        end
      end
      if (bus.o_hs && !bus.o_pclk && (hb % 2 == 0)) begin
        checks++;
        if (rd_stamp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_latency: pixel byte at cyc %0d with no prior strobe", cyc);
        end else begin
          m_s = rd_stamp_q.pop_front();
          if (cyc - m_s !== 2) begin
            failures++;
            $display("FAIL rd_latency: got %0d clk want 2", cyc - m_s);
          end
        end
      end
      if (bus.o_hs && bus.o_pclk) begin
        checks++;
        if (exp_byte_q.size() == 0) begin
          failures++;
          $display("FAIL byte: extra byte %h", bus.o_data);
        end else begin
          m_b = exp_byte_q.pop_front();
          if (bus.o_data !== m_b) begin
            failures++;
            $display("FAIL byte: got %h want %h", bus.o_data, m_b);
          end
        end
        hb++;
      end
      if (!bus.o_hs) begin
        hb = 0;
        checks++;
        if (bus.o_data !== 8'h00) begin
          failures++;
          $display("FAIL blank_data: got %h want 00", bus.o_data);
        end
      end
    end
  end

  task automatic push_frame_expect();
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 4; k++) begin
        logic [11:0] w;
        w = {4'(l), 4'(k), 4'hA};
        exp_byte_q.push_back({4'h0, w[11:8]});
        exp_byte_q.push_back(w[7:0]);
        exp_addr_q.push_back({9'(l), 10'(k)});
      end
  endtask

  task automatic clear_sb();
    exp_byte_q.delete();
    exp_addr_q.delete();
    rd_stamp_q.delete();
    hb = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.o_rd_en, bus.o_pclk, bus.o_vs, bus.o_hs, bus.o_data, bus.o_busy, bus.o_frame_done} !== 14'h0) begin
        failures++;
        $display("FAIL reset_outs: got busy=%b vs=%b hs=%b pclk=%b data=%h", bus.o_busy, bus.o_vs, bus.o_hs, bus.o_pclk, bus.o_data);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_vs !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_pclk !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got vs=%b busy=%b pclk=%b want 1 1 0", bus.o_vs, bus.o_busy, bus.o_pclk);
    end
    en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_vs !== 1'b0) begin
      failures++;
      $display("FAIL reset_again: got busy=%b vs=%b want 0 0", bus.o_busy, bus.o_vs);
    end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int vs_n = 0, hs_n = 0, win = 0, done_at = -1, done_n = 0;
    logic hs_prev = 1'b0, vs0 = 1'b0, vs24 = 1'b1, busy144 = 1'b1, pclk144 = 1'b1;
    clear_sb();
    push_frame_expect();
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (bus.o_vs) vs_n++;
      if (bus.o_hs) hs_n++;
      if (bus.o_hs && !hs_prev) win++;
      hs_prev = bus.o_hs;
      if (bus.o_frame_done) begin done_n++; if (done_at < 0) done_at = i; end
      if (i == 0) vs0 = bus.o_vs;
      if (i == 24) vs24 = bus.o_vs;
      if (i == 144) begin busy144 = bus.o_busy; pclk144 = bus.o_pclk; end
      @(negedge clk);
    end
    checks++;
    if (vs_n !== 24 || vs0 !== 1'b1 || vs24 !== 1'b0) begin
      failures++;
      $display("FAIL sf_vsync: got %0d clk (first=%b, at24=%b) want 24 clk from clk 0", vs_n, vs0, vs24);
    end
    checks++;
    if (win !== 3 || hs_n !== 48) begin
      failures++;
      $display("FAIL sf_href: got %0d windows %0d clk want 3 windows 48 clk", win, hs_n);
    end
    checks++;
    if (done_at !== 143 || done_n !== 1) begin
      failures++;
      $display("FAIL sf_done: got clk %0d count %0d want clk 143 count 1", done_at, done_n);
    end
    checks++;
    if (busy144 !== 1'b0 || pclk144 !== 1'b0) begin
      failures++;
      $display("FAIL sf_idle: got busy=%b pclk=%b want 0 0", busy144, pclk144);
    end
    checks++;
    if (exp_byte_q.size() != 0 || exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL sf_drain: got %0d bytes %0d addrs left want 0 0", exp_byte_q.size(), exp_addr_q.size());
    end
  endtask

  task automatic test_read_port();
    int rd_n = 0, first = -1, last = -1;
    clear_sb();
    push_frame_expect();
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (bus.o_rd_en) begin
        rd_n++;
        if (first < 0) first = i;
        last = i;
      end
      @(negedge clk);
    end
    checks++;
    if (rd_n !== 12) begin
      failures++;
      $display("FAIL rp_count: got %0d strobes want 12", rd_n);
    end
    checks++;
    if (first !== 46 || last !== 106) begin
      failures++;
      $display("FAIL rp_window: got first=%0d last=%0d want 46 106", first, last);
    end
    checks++;
    if (exp_addr_q.size() != 0 || rd_stamp_q.size() != 0) begin
      failures++;
      $display("FAIL rp_drain: got %0d addrs %0d stamps left want 0 0", exp_addr_q.size(), rd_stamp_q.size());
    end
  endtask

  task automatic test_continuous();
    int d0 = -1, d1 = -1, dn = 0;
    logic vs_after = 1'b0, busy_end = 1'b1;
    clear_sb();
    push_frame_expect();
    push_frame_expect();
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if (bus.o_frame_done) begin
        dn++;
        if (d0 < 0) d0 = i; else if (d1 < 0) d1 = i;
      end
      if (i == 144) vs_after = bus.o_vs;
      if (i == 150) en = 1'b0;
      if (i == 295) busy_end = bus.o_busy;
      @(negedge clk);
    end
    checks++;
    if (d0 !== 143 || d1 - d0 !== 144 || dn !== 2) begin
      failures++;
      $display("FAIL cont_done: got d0=%0d d1=%0d count=%0d want 143 287 2", d0, d1, dn);
    end
    checks++;
    if (vs_after !== 1'b1) begin
      failures++;
      $display("FAIL cont_gap: got vs=%b on clk after done want 1", vs_after);
    end
    checks++;
    if (busy_end !== 1'b0 || exp_byte_q.size() != 0) begin
      failures++;
      $display("FAIL cont_end: got busy=%b bytes_left=%0d want 0 0", busy_end, exp_byte_q.size());
    end
  endtask

  task automatic test_en_drop();
    int done_at = -1;
    logic busy100 = 1'b0, busy145 = 1'b1;
    clear_sb();
    push_frame_expect();
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      if (i == 60) en = 1'b0;
      if (bus.o_frame_done && done_at < 0) done_at = i;
      if (i == 100) busy100 = bus.o_busy;
      if (i == 145) busy145 = bus.o_busy;
      @(negedge clk);
    end
    checks++;
    if (done_at !== 143 || busy100 !== 1'b1) begin
      failures++;
      $display("FAIL drop_done: got done=%0d busy@100=%b want 143 1", done_at, busy100);
    end
    checks++;
    if (busy145 !== 1'b0 || exp_byte_q.size() != 0) begin
      failures++;
      $display("FAIL drop_idle: got busy=%b bytes_left=%0d want 0 0", busy145, exp_byte_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int done_at = -1;
    logic vs0 = 1'b0;
    clear_sb();
    push_frame_expect();
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (76) @(negedge clk);
    checks++;
    if (bus.o_hs !== 1'b1 || bus.o_pclk !== 1'b0 || bus.o_data !== 8'h01) begin
      failures++;
      $display("FAIL mid_pos: got hs=%b pclk=%b data=%h want 1 0 01", bus.o_hs, bus.o_pclk, bus.o_data);
    end
    mon_on = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if ({bus.o_hs, bus.o_data, bus.o_pclk, bus.o_busy, bus.o_vs} !== 12'h0) begin
      failures++;
      $display("FAIL mid_reset: got hs=%b data=%h pclk=%b busy=%b want all 0", bus.o_hs, bus.o_data, bus.o_pclk, bus.o_busy);
    end
    @(negedge clk);
    clear_sb();
    push_frame_expect();
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (i == 0) vs0 = bus.o_vs;
      if (bus.o_frame_done && done_at < 0) done_at = i;
      @(negedge clk);
    end
    checks++;
    if (vs0 !== 1'b1 || done_at !== 143 || exp_byte_q.size() != 0) begin
      failures++;
      $display("FAIL mid_restart: got vs0=%b done=%0d bytes_left=%0d want 1 143 0", vs0, done_at, exp_byte_q.size());
    end
    mon_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_read_port();
    test_continuous();
    test_en_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
